// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types for the RAM port arbiter.
package ram_ctrl_pkg;
    typedef enum logic {CLEAR, SERVE} state_t;
    typedef logic req_id_t;
    localparam int NUM_REQ = 2;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes, clear control and RAM port of the arbiter.
interface ram_port_arbiter_if #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic                 clear_start;
    logic                 clear_busy;
    logic                 req_valid_0, req_valid_1;
    logic                 req_ready_0, req_ready_1;
    logic                 req_we_0, req_we_1;
    logic [AW-1:0]        req_addr_0, req_addr_1;
    logic [MEM_WIDTH-1:0] req_wdata_0, req_wdata_1;
    logic                 rsp_valid_0, rsp_valid_1;
    logic [MEM_WIDTH-1:0] rsp_rdata_0, rsp_rdata_1;
    logic                 ram_enable, ram_write_en, ram_reset;
    logic [AW-1:0]        ram_address;
    logic [MEM_WIDTH-1:0] ram_data_in;
    logic [MEM_WIDTH-1:0] ram_data_out;
    modport slave (
        input  clear_start, req_valid_0, req_valid_1, req_we_0, req_we_1,
               req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, ram_data_out,
        output clear_busy, req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_rdata_0, rsp_rdata_1, ram_enable, ram_write_en, ram_reset,
               ram_address, ram_data_in
    );
    modport master (
        output clear_start, req_valid_0, req_valid_1, req_we_0, req_we_1,
               req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, ram_data_out,
        input  clear_busy, req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_rdata_0, rsp_rdata_1, ram_enable, ram_write_en, ram_reset,
               ram_address, ram_data_in
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; priority moves only on a completed grant.
module rr_arbiter_2
    import ram_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    logic ptr;  // 1 = requester 1 wins the next tie
    assign grant[0] = valid[0] & (~valid[1] | ~ptr);
    assign grant[1] = valid[1] & (~valid[0] | ptr);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ptr <= 1'b0;
        else if (advance) ptr <= grant[0];
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants one of two requesters per cycle onto a single-port RAM,
// returns read data to the issuer and zero-fills the RAM after reset or on command.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024
) (
    input logic             clock,
    input logic             reset_n,
    ram_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    state_t             state;
    logic [AW-1:0]      count;
    logic               tag_valid;
    req_id_t            tag_id;
    logic [NUM_REQ-1:0] valid, grant;
    logic               clearing, last, we_sel;
    assign clearing = state == CLEAR;
    assign last     = count == AW'(MEM_DEPTH - 1);
    assign valid    = (!clearing && !bus.clear_start) ? {bus.req_valid_1, bus.req_valid_0} : '0;
    assign we_sel   = grant[1] ? bus.req_we_1 : bus.req_we_0;
    rr_arbiter_2 u_arb (
        .clock  (clock),
        .reset_n(reset_n),
        .valid  (valid),
        .advance(|grant),
        .grant  (grant)
    );
    assign bus.req_ready_0 = grant[0];
    assign bus.req_ready_1 = grant[1];
    // The clear drives are gated by reset_n so the RAM sees no access while reset is held
    assign bus.ram_enable   = clearing ? reset_n : |grant;
    assign bus.ram_write_en = clearing ? reset_n : |grant & we_sel;
    assign bus.ram_reset    = clearing & reset_n;
    assign bus.ram_address  = clearing ? count : grant[1] ? bus.req_addr_1 : bus.req_addr_0;
    assign bus.ram_data_in  = clearing ? '0 : grant[1] ? bus.req_wdata_1 : bus.req_wdata_0;
    assign bus.rsp_valid_0  = tag_valid & (tag_id == 1'b0);
    assign bus.rsp_valid_1  = tag_valid & (tag_id == 1'b1);
    assign bus.rsp_rdata_0  = bus.ram_data_out;
    assign bus.rsp_rdata_1  = bus.ram_data_out;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= CLEAR;
            count          <= '0;
            bus.clear_busy <= 1'b1;
            tag_valid      <= 1'b0;
            tag_id         <= 1'b0;
        end else begin
            tag_valid <= |grant & ~we_sel;
            tag_id    <= req_id_t'(grant[1]);
            if (clearing) begin
                count          <= last ? '0 : count + 1'b1;
                state          <= last ? SERVE : CLEAR;
                bus.clear_busy <= ~last;
            end else if (bus.clear_start) begin
                state          <= CLEAR;
                bus.clear_busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random stimulus checked against a transaction-level
// model of the arbiter (memory image, last-granted requester, pending read response).
module tb_ram_port_arbiter;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    ram_port_arbiter_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();
    ram_port_arbiter #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [W-1:0] ram [D];
    logic [W-1:0] ram_q;
    always @(posedge clock) begin
        if (bus.ram_enable) begin
            if (bus.ram_write_en) ram[bus.ram_address] <= bus.ram_data_in;
            else ram_q <= ram[bus.ram_address];
        end
    end
    assign bus.ram_data_out = ram_q;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] ref_mem [D];
    bit           m_busy;
    int           m_cnt;
    int           m_last;
    bit           p_valid;
    int           p_id;
    logic [W-1:0] p_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                         input bit cs);
        bus.req_valid_0 = v0; bus.req_we_0 = we0; bus.req_addr_0 = a0; bus.req_wdata_0 = d0;
        bus.req_valid_1 = v1; bus.req_we_1 = we1; bus.req_addr_1 = a1; bus.req_wdata_1 = d1;
        bus.clear_start = cs;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_check();
        int           win;
        logic [1:0]   exp_ready;
        bit           we;
        logic [AW-1:0] addr;
        logic [W-1:0] data;
        check("rsp_valid", {bus.rsp_valid_1, bus.rsp_valid_0},
              {p_valid && p_id == 1, p_valid && p_id == 0});
        if (p_valid) check("rsp_data", p_id == 1 ? bus.rsp_rdata_1 : bus.rsp_rdata_0, p_data);
        p_valid = 0;
        check("clear_busy", bus.clear_busy, m_busy);
        if (m_busy) begin
            check("ready_in_clear", {bus.req_ready_1, bus.req_ready_0}, 0);
            check("clear_ctl", {bus.ram_enable, bus.ram_write_en, bus.ram_reset}, 3'b111);
            check("clear_addr", bus.ram_address, m_cnt);
            check("clear_data", bus.ram_data_in, 0);
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) begin
                m_busy = 0;
                m_cnt = 0;
            end
        end else begin
            win = -1;
            if (!bus.clear_start) begin
                if (bus.req_valid_0 && bus.req_valid_1) win = (m_last == 0) ? 1 : 0;
                else if (bus.req_valid_0) win = 0;
                else if (bus.req_valid_1) win = 1;
            end
            exp_ready = (win < 0) ? 2'b00 : (win == 1) ? 2'b10 : 2'b01;
            check("ready", {bus.req_ready_1, bus.req_ready_0}, exp_ready);
            check("ram_en_rst", {bus.ram_enable, bus.ram_reset}, {win >= 0, 1'b0});
            if (win >= 0) begin
                we   = (win == 1) ? bus.req_we_1 : bus.req_we_0;
                addr = (win == 1) ? bus.req_addr_1 : bus.req_addr_0;
                data = (win == 1) ? bus.req_wdata_1 : bus.req_wdata_0;
                check("ram_we", bus.ram_write_en, we);
                check("ram_addr", bus.ram_address, addr);
                if (we) begin
                    check("ram_din", bus.ram_data_in, data);
                    ref_mem[addr] = data;
                end else begin
                    p_valid = 1;
                    p_id    = win;
                    p_data  = ref_mem[addr];
                end
                m_last = win;
            end else begin
                check("ram_we_idle", bus.ram_write_en, 0);
            end
            if (bus.clear_start) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        model_check();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        check("rst_busy", bus.clear_busy, 1);
        check("rst_ready", {bus.req_ready_1, bus.req_ready_0}, 0);
        check("rst_rsp", {bus.rsp_valid_1, bus.rsp_valid_0}, 0);
        check("rst_ram_en", bus.ram_enable, 0);
        repeat (n) @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_busy  = 1;
        m_cnt   = 0;
        m_last  = 1;
        p_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = 'x;
        end
        idle();
        #2;
        do_reset(2);
        repeat (D) cycle();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0); cycle();
        idle(); cycle();
        // write by 0, read back by 1
        drive(1, 1, 3, 32'hA5A5_0001, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 3, 0, 0); cycle();
        idle(); cycle();
        // sustained tie: alternating grants and responses
        drive(1, 1, 1, 32'h1111_0001, 1, 1, 2, 32'h2222_0002, 0); cycle(); cycle();
        drive(1, 0, 1, 0, 1, 0, 2, 0, 0); repeat (6) cycle();
        idle(); cycle();
        // requester 1 alone, then a tie goes to requester 0
        drive(0, 0, 0, 0, 1, 0, 2, 0, 0); repeat (3) cycle();
        drive(1, 0, 1, 0, 1, 0, 2, 0, 0); cycle(); cycle();
        idle(); cycle();
        // clear_start blocks a concurrent request; prior read still answers
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 3, 0, 0, 0, 0, 0, 1); cycle();
        idle(); repeat (D) cycle();
        for (int a = 0; a < D; a++) begin
            drive(0, 0, 0, 0, 1, 0, AW'(a), 0, 0); cycle();
        end
        idle(); cycle();
        // reset mid-CLEAR
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
        drive(1, 0, 4, 0, 0, 0, 0, 0, 0); repeat (5) cycle();
        do_reset(1);
        repeat (D) cycle();
        // reset mid-SERVE with a read in flight
        drive(1, 1, 7, 32'h7777_0007, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 7, 0, 1, 0, 6, 0, 0); cycle();
        do_reset(1);
        idle();
        repeat (D) cycle();
        repeat (400) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, D - 1)), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, D - 1)), $urandom,
                  $urandom_range(0, 49) == 0);
            cycle();
        end
        idle(); cycle(); cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
